matvec_result_streamer: RTL and testbench
=========================================

// Module: matvec_result_streamer
// PURPOSE
//  Output-side companion to matvec_mul: tracks launches into the multiplier and captures each y vector
//  when it emerges LATENCY cycles later. Buffers captured vectors in a DEPTH-entry FIFO and streams
//  them out one W_Y-bit row per beat on a valid/ready interface.
//  Drives matvec_mul's cen, so the multiplier pipeline freezes instead of dropping results when downstream stalls.
// PARAMETERS
//  R        2                    rows of y (elements per output vector)
//  C        5                    columns of k/x; sets the multiplier latency
//  W_X      3                    bitwidth of x elements
//  W_K      4                    bitwidth of k elements
//  W_Y      W_X+W_K+$clog2(C)    bitwidth of y elements (derived, do not override)
//  LATENCY  $clog2(C)+1          matvec_mul cycles from sampled input to valid y (derived)
//  DEPTH    4                    result FIFO entries, each a full R-element vector; power of 2, >=2
// PORTS
//  clk      in   1              clock, all logic on rising edge
//  rst      in   1              synchronous reset, active-high
//  in_valid in   1              upstream presents a new x/k to matvec_mul this cycle
//  in_ready out  1              equals cen; launch accepted when in_valid && in_ready
//  cen      out  1              clock enable to matvec_mul
//  y        in   R*W_Y          signed [R-1:0][W_Y-1:0] result vector from matvec_mul
//  m_valid  out  1              output row valid
//  m_ready  in   1              downstream accepts row
//  m_data   out  W_Y            signed row value y[m_row] of FIFO head vector
//  m_row    out  max(1,$clog2(R)) row index of m_data, 0..R-1
//  m_last   out  1              high with m_valid on row R-1 (last beat of vector)
// BEHAVIOUR
//  Reset (rst=1 at edge): tag pipe, FIFO count/pointers, row counter -> 0. cen=0 while rst high.
//   Outputs while/after reset: m_valid=0, m_last=0, m_row=0, m_data=0 (head masked while empty).
//  cen = !rst && (count != DEPTH); combinational from registered count; in_ready = cen.
//  Tag pipe tag[0..LATENCY-1], advances only on edges with cen=1:
//   tag[0] <= in_valid; tag[i] <= tag[i-1]. With cen=0 the tag pipe holds, mirroring the frozen multiplier.
//  Capture: on edge with cen && tag[LATENCY-1], write y into FIFO tail, count++.
//   y is valid exactly while tag[LATENCY-1]=1; cen=1 guarantees room, so no overflow or drop is possible.
//  Latency: in_valid accepted at edge N -> vector in FIFO after edge N+LATENCY -> m_valid in that cycle if FIFO was empty.
//  Output FSM (row counter): m_valid = (count!=0); m_data = head[row]; m_last = m_valid && row==R-1.
//   On m_valid && m_ready: row==R-1 -> row<=0 and pop head (count--, rd ptr wrap); else row<=row+1.
//  Simultaneous capture and pop: count unchanged, both pointers advance.
//  cen stays 0 during a pop cycle; it reopens the edge after count drops. Full pointer wrap-around mod DEPTH.
//  m_valid && !m_ready: m_data, m_row, m_last hold stable until the handshake (AXI-style). m_valid never drops without a handshake.
//  Pop-then-empty: m_valid falls the cycle after the last beat unless a capture happened on the same edge.
//  Arithmetic: none. Data are passed bit-exact as signed W_Y values; no truncation or extension.
//  Reset mid-operation: in-flight tags and buffered vectors are discarded. No stale beat follows reset.
//   Results still inside matvec_mul are ignored because their tags are cleared.
// TESTING (R=2,C=5,W_X=3,W_K=4 -> W_Y=10, LATENCY=4, DEPTH=4; reference model = tb golden y_exp)
//  1 Single launch, x=all 1, k row0=all 1, row1=all 2, m_ready=1
//    -> m_valid 4 cycles after acceptance
//    -> beats (m_row,m_data,m_last) = (0,5,0),(1,10,1); then m_valid=0.
//  2 Signed extremes x=all -4, k row0=all -8, row1=all 7
//    -> beats 160 then -140 (10-bit: 0x0A0, 0x374).
//  3 Backpressure: m_ready=0, 8 launches on consecutive cycles with in_valid held
//    -> cen falls once count=4; y/tags frozen; no launch lost.
//    -> then m_ready=1 -> 16 beats in launch order, each matching y_exp.
//  4 Random m_ready (50%) plus random in_valid, 100 random vectors
//    -> every beat matches golden; m_data stable while stalled; m_last only on row 1.
//  5 Capture and pop on the same edge with count=1 -> count stays 1, no beat skipped or duplicated.
//  6 Assert rst for 1 cycle with 2 vectors buffered and 2 in flight
//    -> m_valid=0 next cycle; cen=1 after rst low; no stale beats; next launch streams correctly.

Source files
------------

// File: rtl/matvec_result_streamer.sv
// matvec_result_streamer: tracks launches into matvec_mul, captures each y
// vector when its tag emerges, buffers it and streams it out row by row.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  launch handshake toward matvec_mul (in_ready == cen)
//   cen                clock enable to matvec_mul (freezes it when full)
//   y                  R x W_Y result vector from matvec_mul
//   m_valid/m_ready    output row handshake
//   m_data/m_row       row value and row index of the FIFO head vector
//   m_last             last row of the current vector
module matvec_result_streamer #(
    parameter int R     = 2,
    parameter int C     = 5,
    parameter int W_X   = 3,
    parameter int W_K   = 4,
    parameter int DEPTH = 4,
    localparam int W_Y     = W_X + W_K + $clog2(C),
    localparam int LATENCY = $clog2(C) + 1,
    localparam int RW      = (R > 1) ? $clog2(R) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              cen,
    input  logic signed [R-1:0][W_Y-1:0]      y,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic signed [W_Y-1:0]             m_data,
    output logic        [RW-1:0]              m_row,
    output logic                              m_last
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [RW-1:0] LAST_ROW = RW'(R - 1);

    logic [LATENCY-1:0]      tag_q, tag_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           wr_q, wr_d;
    logic [PW-1:0]           rd_q, rd_d;
    logic [RW-1:0]           row_q, row_d;
    logic [R-1:0][W_Y-1:0]   mem_q [DEPTH];

    logic cap;
    logic beat;
    logic pop;

    // Full FIFO freezes the multiplier; results already in flight
    // are held inside it rather than dropped.
    assign cen      = !rst && (cnt_q != FULL);
    assign in_ready = cen;

    assign m_valid = !rst && (cnt_q != '0);
    assign m_last  = m_valid && (row_q == LAST_ROW);
    assign m_row   = m_valid ? row_q : '0;
    assign m_data  = m_valid ? mem_q[rd_q][row_q] : '0;

    // y is only meaningful while the oldest tag is set; the tag pipe
    // moves in lockstep with the multiplier pipeline.
    assign cap  = cen && tag_q[LATENCY-1];
    assign beat = m_valid && m_ready;
    assign pop  = beat && (row_q == LAST_ROW);

    always_comb begin
        tag_d = tag_q;
        if (cen) begin
            tag_d[0] = in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                tag_d[i] = tag_q[i-1];
            end
        end
    end

    always_comb begin
        wr_d  = cap ? wr_q + PW'(1) : wr_q;
        rd_d  = pop ? rd_q + PW'(1) : rd_q;
        row_d = row_q;
        if (beat) begin
            row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({cap, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= '0;
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            row_q <= '0;
        end else begin
            tag_q <= tag_d;
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            row_q <= row_d;
        end
    end

    // Storage needs no reset: reads are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (cap) begin
            mem_q[wr_q] <= y;
        end
    end

endmodule

// File: tb/tb_matvec_result_streamer.sv
// tb_matvec_result_streamer: random launches through a behavioural
// multiplier model, beats scored against golden matrix-vector products.
module tb_matvec_result_streamer;

    localparam int R     = 2;
    localparam int C     = 5;
    localparam int W_X   = 3;
    localparam int W_K   = 4;
    localparam int DEPTH = 4;
    localparam int W_Y   = W_X + W_K + $clog2(C);
    localparam int LAT   = $clog2(C) + 1;
    localparam int RW    = 1;

    typedef logic [R-1:0][W_Y-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic m_ready = 1'b0;
    logic in_ready;
    logic cen;
    logic m_valid;
    logic m_last;
    logic signed [W_Y-1:0] m_data;
    logic [RW-1:0] m_row;
    vec_t y = '0;

    always #5 clk = ~clk;

    matvec_result_streamer #(
        .R(R), .C(C), .W_X(W_X), .W_K(W_K), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .cen(cen),
        .y(y),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_row(m_row),
        .m_last(m_last)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic signed [W_X-1:0] xv [C];
    logic signed [W_K-1:0] kv [R][C];
    vec_t stg [LAT];

    int bq_row[$];
    int bq_dat[$];
    int log_row[$];
    int log_dat[$];
    int log_last[$];

    bit hold = 0;
    int p_dat, p_row, p_last;
    bit acc_last = 0;
    bit obs_mv, obs_cen;
    int mv_run = 0;
    int mv_best = 0;

    function automatic vec_t golden();
        vec_t v;
        for (int r = 0; r < R; r++) begin
            int s = 0;
            for (int c = 0; c < C; c++) begin
                s += int'(kv[r][c]) * int'(xv[c]);
            end
            v[r] = W_Y'(s);
        end
        return v;
    endfunction

    task automatic rand_vec();
        for (int c = 0; c < C; c++) xv[c] = W_X'($urandom);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) kv[r][c] = W_K'($urandom);
    endtask

    task automatic set_const(input int xval, input int k0, input int k1);
        for (int c = 0; c < C; c++) begin
            xv[c]    = W_X'(xval);
            kv[0][c] = W_K'(k0);
            kv[1][c] = W_K'(k1);
        end
    endtask

    task automatic tick();
        bit   acc;
        bit   cyc_cen;
        vec_t g;
        @(negedge clk);
        obs_mv  = m_valid;
        obs_cen = cen;
        if (rst) begin
            chk("rst_valid", m_valid, 0);
            chk("rst_cen", cen, 0);
            chk("rst_last", m_last, 0);
            chk("rst_row", m_row, 0);
            chk("rst_data", m_data, 0);
        end
        if (hold && !rst) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, p_dat);
            chk("stall_row", m_row, p_row);
            chk("stall_last", m_last, p_last);
        end
        if (!m_valid) chk("last_novalid", m_last, 0);
        if (m_valid) begin
            if (bq_row.size() == 0) begin
                chk("stale_beat", m_valid, 0);
            end else if (m_ready) begin
                chk("beat_row", m_row, bq_row[0]);
                chk("beat_data", m_data, bq_dat[0]);
                chk("beat_last", m_last, int'(bq_row[0] == R - 1));
                void'(bq_row.pop_front());
                void'(bq_dat.pop_front());
                log_row.push_back(int'(m_row));
                log_dat.push_back(int'(m_data));
                log_last.push_back(int'(m_last));
            end
        end
        mv_run = m_valid ? mv_run + 1 : 0;
        if (mv_run > mv_best) mv_best = mv_run;
        hold    = m_valid && !m_ready;
        p_dat   = int'(m_data);
        p_row   = int'(m_row);
        p_last  = int'(m_last);
        acc     = in_valid && cen;
        cyc_cen = cen;
        g       = golden();
        acc_last = acc;
        @(posedge clk);
        if (rst) begin
            bq_row.delete();
            bq_dat.delete();
            hold = 0;
        end
        if (acc) begin
            for (int r = 0; r < R; r++) begin
                bq_row.push_back(r);
                bq_dat.push_back(int'($signed(g[r])));
            end
        end
        if (cyc_cen) begin
            for (int i = LAT - 1; i > 0; i--) stg[i] = stg[i-1];
            stg[0] = acc ? g : vec_t'($urandom);
        end
        #1;
        y = stg[LAT-1];
    endtask

    task automatic launch();
        int n = 0;
        in_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!acc_last && n < 50);
        in_valid = 1'b0;
        chk("launch_accept", acc_last, 1);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        in_valid = 1'b0;
        m_ready  = 1'b1;
        while (bq_row.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_empty", bq_row.size(), 0);
        repeat (LAT + 3) tick();
        chk("idle_valid", m_valid, 0);
    endtask

    task automatic clear_log();
        log_row.delete();
        log_dat.delete();
        log_last.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        bit seen_low;

        for (int i = 0; i < LAT; i++) stg[i] = '0;
        set_const(0, 0, 0);

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("cen_after_rst", obs_cen, 1);

        // single launch, latency and beat order
        clear_log();
        set_const(1, 1, 2);
        m_ready = 1'b1;
        launch();
        n = 0;
        do begin
            tick();
            n++;
        end while (!obs_mv && n < 20);
        chk("latency", n - 1, 4);
        drain(20);
        chk("t1_beats", log_row.size(), 2);
        if (log_row.size() == 2) begin
            chk("t1_row0", log_row[0], 0);
            chk("t1_dat0", log_dat[0], 5);
            chk("t1_last0", log_last[0], 0);
            chk("t1_row1", log_row[1], 1);
            chk("t1_dat1", log_dat[1], 10);
            chk("t1_last1", log_last[1], 1);
        end

        // signed extremes
        clear_log();
        set_const(-4, -8, 7);
        launch();
        drain(20);
        chk("t2_beats", log_dat.size(), 2);
        if (log_dat.size() == 2) begin
            chk("t2_dat0", log_dat[0], 160);
            chk("t2_dat1", log_dat[1], -140);
        end

        // backpressure: 8 launches into a stalled output
        clear_log();
        m_ready  = 1'b0;
        rand_vec();
        in_valid = 1'b1;
        cnt = 0;
        n = 0;
        seen_low = 0;
        while (cnt < 8 && n < 200) begin
            tick();
            n++;
            if (!obs_cen) seen_low = 1;
            if (acc_last) begin
                cnt++;
                rand_vec();
            end
        end
        in_valid = 1'b0;
        chk("bp_launches", cnt, 8);
        repeat (3) tick();
        if (!obs_cen) seen_low = 1;
        chk("bp_cen_low", seen_low, 1);
        chk("bp_full_cen", cen, 0);
        drain(200);
        chk("bp_beats", log_row.size(), 16);

        // random traffic with random backpressure
        in_valid = 1'b0;
        acc_last = 0;
        cnt = 0;
        n = 0;
        rand_vec();
        while (cnt < 100 && n < 5000) begin
            if (!in_valid || acc_last) begin
                if (acc_last) rand_vec();
                in_valid = 1'($urandom_range(0, 1));
            end
            m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
            if (acc_last) cnt++;
        end
        chk("rand_launches", cnt, 100);
        drain(2000);

        // capture and pop on the same edge with one entry buffered
        m_ready = 1'b1;
        rand_vec();
        launch();
        tick();
        rand_vec();
        launch();
        mv_best = 0;
        mv_run  = 0;
        drain(40);
        chk("samedge_run", mv_best, 4);

        // reset with two vectors buffered and two in flight
        m_ready  = 1'b0;
        rand_vec();
        in_valid = 1'b1;
        cnt = 0;
        n = 0;
        while (cnt < 4 && n < 50) begin
            tick();
            n++;
            if (acc_last) begin
                cnt++;
                rand_vec();
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_valid", m_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid", obs_mv, 0);
        chk("post_rst_cen", obs_cen, 1);
        clear_log();
        m_ready = 1'b1;
        rand_vec();
        launch();
        drain(50);
        chk("post_rst_beats", log_row.size(), 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
